// File: rtl/atm_pkg.sv
// Shared constants, cell framing state and the HEC CRC-8 step for the ATM cell reader.
package atm_pkg;

    localparam int ATM_CELL_BYTES = 53;
    localparam int ATM_HDR_BYTES  = 4;
    localparam int ATM_HEC_IDX    = 4;
    localparam logic [7:0] ATM_HEC_COSET = 8'h55;
    localparam logic [7:0] ATM_HEC_POLY  = 8'h07;

    typedef enum logic {
        HDR = 1'b0,
        PAY = 1'b1
    } cell_state_t;

    // One byte of CRC-8 (x^8+x^2+x+1), MSB first.
    function automatic logic [7:0] hec_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ ATM_HEC_POLY;
            else                c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/atm_skid_buf.sv
// Two-entry skid buffer holding tagged cell bytes {sop, eop, data}; entry 0 is always the head.
module atm_skid_buf (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [9:0] din,
    input  logic       pop,
    output logic [9:0] dout,
    output logic [1:0] occ
);

    logic [9:0] e0_q, e1_q;
    logic [1:0] occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) e0_q <= din;
                    else               e1_q <= din;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: occupancy unchanged, shift when two deep.
                    if (occ_q == 2'd1) begin
                        e0_q <= din;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = e0_q;
    assign occ  = occ_q;

endmodule

// File: rtl/atm_cell_reader.sv
// Pops bytes from the ingress FIFO, frames 53-byte UNI cells, checks HEC, extracts header
// fields and forwards bytes downstream on a valid/ready stream with saturating statistics.
//
// state | meaning
// HDR   | bytes 0-4: header bytes into CRC, HEC compare at byte 4
// PAY   | bytes 5-52: payload, wrap to HDR after byte 52
module atm_cell_reader
    import atm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_dout,
    output logic             fifo_read,
    output logic [7:0]       cell_data,
    output logic             cell_valid,
    output logic             cell_sop,
    output logic             cell_eop,
    input  logic             cell_ready,
    output logic             hdr_valid,
    output logic [3:0]       hdr_gfc,
    output logic [7:0]       hdr_vpi,
    output logic [15:0]      hdr_vci,
    output logic [2:0]       hdr_pt,
    output logic             hdr_clp,
    output logic             hec_err,
    output logic [CNT_W-1:0] cell_cnt,
    output logic [CNT_W-1:0] hec_err_cnt
);

    localparam logic [5:0] LAST_IDX  = 6'(ATM_CELL_BYTES - 1);
    localparam logic [5:0] HEC_IDX   = 6'(ATM_HEC_IDX);
    localparam logic [5:0] HDR_BYTES = 6'(ATM_HDR_BYTES);

    cell_state_t      state_q;
    logic             inflight_q;
    logic [5:0]       bcnt_q;
    logic [7:0]       crc_q;
    logic [31:0]      hdr_q;
    logic             hdr_valid_q, hec_err_q;
    logic [3:0]       gfc_q;
    logic [7:0]       vpi_q;
    logic [15:0]      vci_q;
    logic [2:0]       pt_q;
    logic             clp_q;
    logic [CNT_W-1:0] cell_cnt_q, hec_err_cnt_q;

    logic       pop;
    logic       last;
    logic [1:0] occ;
    logic [9:0] head;
    logic [2:0] lvl;

    atm_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   ({bcnt_q == 6'd0, bcnt_q == LAST_IDX, fifo_dout}),
        .pop   (pop),
        .dout  (head),
        .occ   (occ)
    );

    assign cell_valid = (occ != 2'd0);
    assign cell_sop   = head[9];
    assign cell_eop   = head[8];
    assign cell_data  = head[7:0];
    assign pop        = cell_valid && cell_ready;
    assign last       = (bcnt_q == LAST_IDX);

    // Bytes already owned (buffered or in flight) minus this cycle's pop must leave room.
    assign lvl       = {1'b0, occ} + {2'b0, inflight_q};
    assign fifo_read = rst_n && !fifo_empty && (lvl < (3'd2 + {2'b0, pop}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HDR;
            inflight_q    <= 1'b0;
            bcnt_q        <= '0;
            crc_q         <= '0;
            hdr_q         <= '0;
            hdr_valid_q   <= 1'b0;
            hec_err_q     <= 1'b0;
            gfc_q         <= '0;
            vpi_q         <= '0;
            vci_q         <= '0;
            pt_q          <= '0;
            clp_q         <= 1'b0;
            cell_cnt_q    <= '0;
            hec_err_cnt_q <= '0;
        end else begin
            inflight_q  <= fifo_read;
            hdr_valid_q <= 1'b0;
            hec_err_q   <= 1'b0;
            if (inflight_q) begin
                bcnt_q <= last ? 6'd0 : bcnt_q + 6'd1;
                case (state_q)
                    HDR: begin
                        if (bcnt_q == HEC_IDX) begin
                            hdr_valid_q <= 1'b1;
                            hec_err_q   <= ((crc_q ^ ATM_HEC_COSET) != fifo_dout);
                            gfc_q       <= hdr_q[31:28];
                            vpi_q       <= hdr_q[27:20];
                            vci_q       <= hdr_q[19:4];
                            pt_q        <= hdr_q[3:1];
                            clp_q       <= hdr_q[0];
                            state_q     <= PAY;
                        end else if (bcnt_q < HDR_BYTES) begin
                            crc_q <= hec_next((bcnt_q == 6'd0) ? 8'h00 : crc_q, fifo_dout);
                            hdr_q <= {hdr_q[23:0], fifo_dout};
                        end
                    end
                    PAY: begin
                        if (last) state_q <= HDR;
                    end
                    default: state_q <= HDR;
                endcase
                if (last && cell_cnt_q != '1) cell_cnt_q <= cell_cnt_q + CNT_W'(1);
            end
            if (hdr_valid_q && hec_err_q && hec_err_cnt_q != '1)
                hec_err_cnt_q <= hec_err_cnt_q + CNT_W'(1);
        end
    end

    assign hdr_valid   = hdr_valid_q;
    assign hec_err     = hec_err_q;
    assign hdr_gfc     = gfc_q;
    assign hdr_vpi     = vpi_q;
    assign hdr_vci     = vci_q;
    assign hdr_pt      = pt_q;
    assign hdr_clp     = clp_q;
    assign cell_cnt    = cell_cnt_q;
    assign hec_err_cnt = hec_err_cnt_q;

endmodule

// File: tb/tb_atm_cell_reader.sv
// Directed bench for atm_cell_reader: FIFO model feeds tagged cells, monitors collect output bytes.
module tb_atm_cell_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_dout = 8'h00;
    logic        cell_ready = 1'b0;
    logic        fifo_read;
    logic [7:0]  cell_data;
    logic        cell_valid, cell_sop, cell_eop;
    logic        hdr_valid, hec_err, hdr_clp;
    logic [3:0]  hdr_gfc;
    logic [7:0]  hdr_vpi;
    logic [15:0] hdr_vci;
    logic [2:0]  hdr_pt;
    logic [15:0] cell_cnt, hec_err_cnt;

    atm_cell_reader #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .fifo_read   (fifo_read),
        .cell_data   (cell_data),
        .cell_valid  (cell_valid),
        .cell_sop    (cell_sop),
        .cell_eop    (cell_eop),
        .cell_ready  (cell_ready),
        .hdr_valid   (hdr_valid),
        .hdr_gfc     (hdr_gfc),
        .hdr_vpi     (hdr_vpi),
        .hdr_vci     (hdr_vci),
        .hdr_pt      (hdr_pt),
        .hdr_clp     (hdr_clp),
        .hec_err     (hec_err),
        .cell_cnt    (cell_cnt),
        .hec_err_cnt (hec_err_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0]  src_q[$];
    logic [9:0]  exp_q[$];
    logic [9:0]  got_q[$];
    logic [32:0] hdr_got[$];

    bit   gap_en = 1'b0;
    int   cyc = 0;
    int   n_reads = 0, first_read = -1, last_read = -1;
    int   n_acc = 0, first_acc = -1, last_acc = -1;
    int   stall_viol = 0, occ_max = 0;
    bit   stall_prev = 1'b0;
    logic [9:0] held = '0;
    int   passed = 0, total = 0;

    // Upstream FIFO: read data appears the cycle after a read, empty flag follows the queue.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_read && !fifo_empty && src_q.size() > 0) fifo_dout <= src_q.pop_front();
        fifo_empty <= (src_q.size() == 0) || (gap_en && $urandom_range(0, 3) == 0);
    end

    always @(negedge clk) begin
        if (fifo_read) begin
            n_reads++;
            if (first_read < 0) first_read = cyc;
            last_read = cyc;
        end
        if (cell_valid && cell_ready) begin
            got_q.push_back({cell_sop, cell_eop, cell_data});
            n_acc++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        if (hdr_valid) hdr_got.push_back({hec_err, hdr_gfc, hdr_vpi, hdr_vci, hdr_pt, hdr_clp});
        if (rst_n && stall_prev && (!cell_valid || {cell_sop, cell_eop, cell_data} != held))
            stall_viol++;
        stall_prev = rst_n && cell_valid && !cell_ready;
        held = {cell_sop, cell_eop, cell_data};
        if (int'(dut.occ) > occ_max) occ_max = int'(dut.occ);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] hec_of(input logic [31:0] h);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 31; i >= 0; i--)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ h[i]) ? 8'h07 : 8'h00);
        return c ^ 8'h55;
    endfunction

    task automatic send_cell(input logic [31:0] h, input logic [7:0] hec,
                             input logic [7:0] base, input logic [7:0] step);
        logic [7:0] b;
        for (int i = 0; i < 53; i++) begin
            if (i < 4)       b = h[31 - 8*i -: 8];
            else if (i == 4) b = hec;
            else             b = base + 8'(int'(step) * (i - 5));
            src_q.push_back(b);
            exp_q.push_back({i == 0, i == 52, b});
        end
    endtask

    task automatic wait_out(input int n, input int budget, input bit toggle);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(posedge clk); #1;
            if (toggle) cell_ready = ~cell_ready;
            k++;
        end
        check("bytes_arrived_in_time", 64'(got_q.size() >= n), 64'd1);
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic compare_stream(input string tag);
        int mism = 0;
        int n;
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) mism++;
        check({tag, "_bytes"}, 64'(mism), 64'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    logic [32:0] h;
    int acc_at_rst;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_fifo_read", 64'(fifo_read), 64'd0);
        check("rst_cell_valid", 64'(cell_valid), 64'd0);
        check("rst_sop_eop_data", 64'({cell_sop, cell_eop, cell_data}), 64'd0);
        check("rst_hdr_valid_err", 64'({hdr_valid, hec_err}), 64'd0);
        check("rst_hdr_fields", 64'({hdr_gfc, hdr_vpi, hdr_vci, hdr_pt, hdr_clp}), 64'd0);
        check("rst_counters", 64'({cell_cnt, hec_err_cnt}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle cell
        cell_ready = 1'b1;
        send_cell(32'h0000_0001, 8'h52, 8'h6A, 8'h00);
        wait_out(53, 400, 1'b0);
        settle();
        check("t1_hdr_count", 64'(hdr_got.size()), 64'd1);
        h = hdr_got.pop_front();
        check("t1_hec_err", 64'(h[32]), 64'd0);
        check("t1_vci", 64'(h[19:4]), 64'h0);
        check("t1_clp", 64'(h[0]), 64'd1);
        compare_stream("t1_stream");
        check("t1_cell_cnt", 64'(cell_cnt), 64'd1);

        // Good then bad HEC
        send_cell(32'h0000_0000, 8'h55, 8'h00, 8'h01);
        send_cell(32'h0000_0000, 8'h56, 8'h80, 8'h03);
        wait_out(106, 800, 1'b0);
        settle();
        check("t2_hdr_count", 64'(hdr_got.size()), 64'd2);
        h = hdr_got.pop_front();
        check("t2_first_hec_err", 64'(h[32]), 64'd0);
        h = hdr_got.pop_front();
        check("t2_second_hec_err", 64'(h[32]), 64'd1);
        check("t2_hec_err_cnt", 64'(hec_err_cnt), 64'd1);
        check("t2_cell_cnt", 64'(cell_cnt), 64'd3);
        compare_stream("t2_stream");

        // Four back-to-back cells, full throughput
        n_reads = 0; first_read = -1; last_read = -1;
        n_acc = 0; first_acc = -1; last_acc = -1;
        send_cell(32'hA53C_7E9B, hec_of(32'hA53C_7E9B), 8'h10, 8'h01);
        send_cell(32'h1234_5678, hec_of(32'h1234_5678), 8'h20, 8'h02);
        send_cell(32'hFFFF_FFFE, hec_of(32'hFFFF_FFFE), 8'h30, 8'h05);
        send_cell(32'h0F0F_0F0F, hec_of(32'h0F0F_0F0F), 8'h40, 8'h07);
        wait_out(212, 800, 1'b0);
        settle();
        check("t3_reads", 64'(n_reads), 64'd212);
        check("t3_read_span", 64'(last_read - first_read + 1), 64'd212);
        check("t3_accepts", 64'(n_acc), 64'd212);
        check("t3_accept_span", 64'(last_acc - first_acc + 1), 64'd212);
        check("t3_hdr_count", 64'(hdr_got.size()), 64'd4);
        h = hdr_got.pop_front();
        check("t3_hdr_fields", 64'(h), 64'({1'b0, 4'hA, 8'h53, 16'hC7E9, 3'd5, 1'b1}));
        hdr_got.delete();
        compare_stream("t3_stream");
        check("t3_cell_cnt", 64'(cell_cnt), 64'd7);
        check("t3_hec_err_cnt", 64'(hec_err_cnt), 64'd1);

        // Ready toggling with random FIFO gaps
        gap_en = 1'b1; occ_max = 0; stall_viol = 0;
        send_cell(32'h0010_0020, hec_of(32'h0010_0020), 8'h01, 8'h01);
        send_cell(32'h0030_0040, hec_of(32'h0030_0040), 8'h55, 8'h03);
        send_cell(32'h5060_7080, hec_of(32'h5060_7080), 8'hC0, 8'h09);
        wait_out(159, 3000, 1'b1);
        gap_en = 1'b0;
        cell_ready = 1'b1;
        settle();
        compare_stream("t4_stream");
        check("t4_stall_stable", 64'(stall_viol), 64'd0);
        check("t4_occ_le_2", 64'(occ_max <= 2), 64'd1);
        check("t4_hdr_count", 64'(hdr_got.size()), 64'd3);
        hdr_got.delete();
        check("t4_cell_cnt", 64'(cell_cnt), 64'd10);

        // Reset in the middle of a cell
        send_cell(32'h1111_2222, hec_of(32'h1111_2222), 8'h77, 8'h01);
        wait_out(20, 200, 1'b0);
        rst_n = 1'b0;
        acc_at_rst = n_acc;
        @(negedge clk);
        check("t5_rst_valid", 64'(cell_valid), 64'd0);
        check("t5_rst_fifo_read", 64'(fifo_read), 64'd0);
        check("t5_rst_counters", 64'({cell_cnt, hec_err_cnt}), 64'd0);
        @(negedge clk);
        check("t5_no_output_in_reset", 64'(n_acc - acc_at_rst), 64'd0);
        src_q.delete();
        got_q.delete();
        exp_q.delete();
        hdr_got.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_cell(32'h0000_0001, 8'h52, 8'h6A, 8'h00);
        repeat (10) @(posedge clk);
        #1;
        check("t5_counters_before_done", 64'({cell_cnt, hec_err_cnt}), 64'd0);
        wait_out(53, 400, 1'b0);
        settle();
        check("t5_first_sop", 64'(got_q.size() > 0 ? got_q[0][9] : 1'b0), 64'd1);
        compare_stream("t5_stream");
        check("t5_cell_cnt", 64'(cell_cnt), 64'd1);
        check("t5_hdr_count", 64'(hdr_got.size()), 64'd1);
        hdr_got.delete();

        // Saturation of the cell counter
        @(negedge clk);
        force dut.cell_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cell_cnt_q;
        @(negedge clk);
        check("t6_preload", 64'(cell_cnt), 64'hFFFE);
        send_cell(32'h0000_0001, 8'h52, 8'h6A, 8'h00);
        wait_out(53, 400, 1'b0);
        settle();
        check("t6_cnt_one_more", 64'(cell_cnt), 64'hFFFF);
        send_cell(32'h0000_0001, 8'h52, 8'h6A, 8'h00);
        send_cell(32'h0000_0001, 8'h52, 8'h6A, 8'h00);
        wait_out(159, 800, 1'b0);
        settle();
        check("t6_cnt_held", 64'(cell_cnt), 64'hFFFF);
        compare_stream("t6_stream");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/atm_cell_reader.md
# atm_cell_reader

Drain side of the ingress byte FIFO (`sync_fifo`) in the ATM switch. Pops bytes from the FIFO and frames them into 53-byte UNI cells. Checks the HEC and extracts the header fields. Forwards cell bytes downstream on a valid/ready stream with start/end-of-cell markers, and keeps saturating cell and HEC-error counters.

## Interface
- `CNT_W`, 16, width of the statistics counters.
- `clk` in 1: single clock, all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_dout` in 8: FIFO read data, valid the cycle after a `fifo_read` issued while `fifo_empty`=0.
- `fifo_read` out 1: FIFO pop request (combinational).
- `cell_data` out 8: cell byte.
- `cell_valid` out 1: `cell_data` valid.
- `cell_sop` out 1: byte 0 of a cell.
- `cell_eop` out 1: byte 52 of a cell.
- `cell_ready` in 1: downstream accepts when `cell_valid`&&`cell_ready`.
- `hdr_valid` out 1: one-cycle pulse, header fields valid.
- `hdr_gfc` out 4, `hdr_vpi` out 8, `hdr_vci` out 16, `hdr_pt` out 3, `hdr_clp` out 1: header fields.
- `hec_err` out 1: qualified by `hdr_valid`; received HEC mismatched.
- `cell_cnt` out CNT_W: completed cells (eop bytes received from the FIFO), saturating.
- `hec_err_cnt` out CNT_W: HEC errors, saturating.

## Operation
- Read issue: `fifo_read = !fifo_empty && (occ + inflight - pop) < 2`.
  - `occ` = skid-buffer occupancy (0..2).
  - `inflight` = registered copy of last cycle's `fifo_read`.
  - `pop` = `cell_valid && cell_ready`.
  - This guarantees no overflow and full throughput (1 byte/cycle) with `cell_ready` held high.
- Byte arrival: when `inflight`=1, `fifo_dout` is pushed into the skid buffer tagged with `{sop,eop}` from the byte counter `bcnt` (0..52). The counter then increments, wrapping 52→0.
- FSM (advances on byte arrival only):
  - HDR: `bcnt` 0–4. Bytes 0–3 are stored into the header register and fed through the CRC-8. At byte 4, compare `crc ^ 8'h55` with the byte, then go to PAY.
  - PAY: `bcnt` 5–52. On byte 52 go to HDR with `bcnt`=0.
- CRC-8:
  - Polynomial x^8+x^2+x+1 (0x07), MSB first, init 0x00.
  - Cleared at byte 0 (byte 0 uses init 0x00 directly).
- Header mapping:
  - GFC = b0[7:4]
  - VPI = {b0[3:0],b1[7:4]}
  - VCI = {b1[3:0],b2,b3[7:4]}
  - PT = b3[3:1]
  - CLP = b3[0]
- Bad-HEC cells are still forwarded unmodified. `hec_err` is informational only.
- Counters:
  - `cell_cnt`+1 on each byte-52 arrival.
  - `hec_err_cnt`+1 on each `hdr_valid`&&`hec_err`.
  - Both hold at 2^CNT_W−1.

## Timing
- Reset values:
  - `fifo_read` is 0 while in reset.
  - `cell_valid`, `cell_sop`, `cell_eop`, `hdr_valid`, `hec_err` are 0.
  - `cell_data` and all header fields are 0.
  - Both counters are 0.
  - `bcnt`=0, FSM=HDR, `occ`=0, `inflight`=0.
- Latency: `fifo_read` at cycle n → byte in the skid buffer at the end of n+1 → presented on `cell_data` at n+2 (buffer was empty).
- `hdr_valid`/`hec_err` are asserted in the cycle after the HEC byte arrives. They do not depend on `cell_ready`.
- Downstream stream rules:
  - `cell_valid` is never retracted before acceptance.
  - `cell_data`, `cell_sop` and `cell_eop` stay stable while `cell_valid`&&!`cell_ready`.
- Empty FIFO mid-cell: framing is preserved. `bcnt` holds and the cell resumes when data returns.
- Simultaneous push and pop: allowed; `occ` is unchanged.
- Reset mid-cell: the partial cell and the buffered bytes are discarded. The first byte after reset is treated as byte 0.

## Structure
- Package `atm_pkg`:
  - Constants: `ATM_CELL_BYTES`=53, `ATM_HDR_BYTES`=4, `ATM_HEC_IDX`=4, `ATM_HEC_COSET`=8'h55, `ATM_HEC_POLY`=8'h07.
  - Function `hec_next(crc, byte)`.
  - Enum `cell_state_t {HDR, PAY}`.
- Sub-module `atm_skid_buf`: 2-entry, 10-bit `{sop,eop,data}` FIFO. Ports: push, pop, occupancy out.

## Test plan
- Idle cell 00 00 00 01 52 plus 48×6A, `cell_ready`=1 → `hdr_valid` pulse with VCI=0, CLP=1, `hec_err`=0; 53 output bytes with sop on 00 and eop on the last 6A; `cell_cnt`=1.
- Unassigned cell 00 00 00 00 55, then a second cell with HEC byte 0x56 → first cell `hec_err`=0, second `hec_err`=1; `hec_err_cnt`=1; both cells forwarded intact.
- Four back-to-back cells, FIFO never empty, `cell_ready`=1 → `fifo_read` high every cycle; 212 bytes accepted in 212 consecutive cycles.
- `cell_ready` toggling 1010… with random FIFO empty gaps → no byte lost or duplicated, sop/eop every 53 bytes, `occ` ≤ 2 at all times.
- `rst_n` pulsed low at byte 20 of a cell, then a fresh cell → no output during reset; the new cell's first byte carries sop; counters read 0 before the new cell completes.
- Force `cell_cnt` to 0xFFFE and send 3 cells → counter reads 0xFFFF and holds.
